dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Imported by the responder top and its storage array.
package dmem_pkg;

    localparam int DEPTH_WORDS_DEF = 1024;
    localparam int LATENCY_DEF     = 2;
    localparam int BE_W            = 4;
    localparam int CNT_W           = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic [31:0] be_merge(
        input logic [31:0]     old_w,
        input logic [31:0]     new_w,
        input logic [BE_W-1:0] be
    );
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word storage with per-byte write enables.
// Read data reflects the addressed word as it was before the same-edge write.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [BE_W-1:0]                wbe,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (wbe[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: accepts one access at a time and
// acknowledges it a fixed number of cycles later.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int LATENCY     = LATENCY_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic [BE_W-1:0] be,
    output logic [31:0]     rdata,
    output logic            ack,
    output logic            err,
    output logic            busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              bad_q, bad_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              bad_in;
    logic [AW-1:0]     arr_addr;
    logic [BE_W-1:0]   arr_wbe;
    logic [31:0]       arr_rdata;
    logic [31:0]       resp_data;

    // Out-of-range addresses are rejected, never wrapped.
    assign bad_in = (addr[1:0] != 2'b00) ||
                    (addr[31:AW+2] != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        bad_d   = bad_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    idx_d   = addr[AW+1:2];
                    wdata_d = wdata;
                    be_d    = be;
                    bad_d   = bad_in;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A write's response is the merged word that gets committed.
    always_comb begin
        resp_data = arr_rdata;
        if (bad_q) begin
            resp_data = '0;
        end else if (we_q) begin
            resp_data = be_merge(arr_rdata, wdata_q, be_q);
        end
    end

    always_comb begin
        ack_d   = (state_d == RESP);
        err_d   = (state_d == RESP) && bad_d;
        rdata_d = (state_q == RESP) ? resp_data : rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            bad_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            bad_q   <= bad_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Idle cycles look up the live address so LATENCY=1 reads are ready.
    assign arr_addr = (state_q == IDLE) ? addr[AW+1:2] : idx_q;
    assign arr_wbe  = (state_q == RESP && we_q && !bad_q) ? be_q : '0;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .addr (arr_addr),
        .wbe  (arr_wbe),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);
    assign rdata = (state_q == RESP) ? resp_data : rdata_q;

endmodule
